// File: rtl/downstream_arbiter.sv
// Round-robin front end that funnels NREQ requesters into a single downstream cache port,
// one transaction at a time, with a bounded wait on the cache's ready.
module downstream_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDXW  = 32,
  parameter int DATAW = 32,
  parameter int TMO   = 16,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CNTW = ($clog2(TMO + 1) > 5) ? $clog2(TMO + 1) : 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_rw,
  input  logic [NREQ*IDXW-1:0]  req_rdindex,
  input  logic [NREQ*IDXW-1:0]  req_wrindex,
  input  logic [NREQ*DATAW-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [DATAW-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  ds_valid,
  output logic                  ds_rw,
  output logic [IDXW-1:0]       ds_rdindex,
  output logic [IDXW-1:0]       ds_wrindex,
  output logic [DATAW-1:0]      ds_data,
  input  logic                  ds_ready,
  input  logic [DATAW-1:0]      ds_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q;
  logic [IDW-1:0]    last_q, gnt_q, rsp_id_q;
  logic [CNTW-1:0]   cnt_q;
  logic              rsp_valid_q, rsp_err_q, ds_valid_q, ds_rw_q;
  logic [DATAW-1:0]  rsp_data_q, ds_data_q;
  logic [IDXW-1:0]   ds_rdindex_q, ds_wrindex_q;

  logic              gnt_found;
  logic [IDW-1:0]    gnt_idx;

  // Search upward from the requester after the last one served, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(last_q) + off;
      if (idx >= NREQ) idx -= NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  assign req_ready = (state_q == IDLE && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= IDW'(NREQ - 1);
      gnt_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      ds_valid_q   <= 1'b0;
      ds_rw_q      <= 1'b0;
      ds_rdindex_q <= '0;
      ds_wrindex_q <= '0;
      ds_data_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (gnt_found) begin
          gnt_q        <= gnt_idx;
          ds_rw_q      <= req_rw[gnt_idx];
          ds_rdindex_q <= req_rdindex[int'(gnt_idx)*IDXW +: IDXW];
          ds_wrindex_q <= req_wrindex[int'(gnt_idx)*IDXW +: IDXW];
          ds_data_q    <= req_data[int'(gnt_idx)*DATAW +: DATAW];
          ds_valid_q   <= 1'b1;
          cnt_q        <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          // A ready arriving on the final permitted cycle still completes normally.
          if (ds_ready) begin
            rsp_data_q  <= ds_rw_q ? '0 : ds_rdata;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= gnt_q;
            ds_valid_q  <= 1'b0;
            state_q     <= RESP;
          end else if (cnt_q == CNTW'(TMO - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= gnt_q;
            ds_valid_q  <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign ds_valid   = ds_valid_q;
  assign ds_rw      = ds_rw_q;
  assign ds_rdindex = ds_rdindex_q;
  assign ds_wrindex = ds_wrindex_q;
  assign ds_data    = ds_data_q;

endmodule

// File: tb/tb_downstream_arbiter.sv
// Directed bench for downstream_arbiter: grants, read/write responses, round-robin order,
// downstream timeout and asynchronous reset in mid-transaction.
module tb_downstream_arbiter;
  logic         clk, rst_n;
  logic [3:0]   req_valid, req_rw, req_ready;
  logic [127:0] req_rdindex, req_wrindex, req_data;
  logic         rsp_valid, rsp_err, ds_valid, ds_rw, ds_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data, ds_rdindex, ds_wrindex, ds_data, ds_rdata;
  int checks = 0;
  int fails  = 0;

  downstream_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rw(req_rw),
    .req_rdindex(req_rdindex), .req_wrindex(req_wrindex), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .ds_valid(ds_valid), .ds_rw(ds_rw), .ds_rdindex(ds_rdindex),
    .ds_wrindex(ds_wrindex), .ds_data(ds_data), .ds_ready(ds_ready), .ds_rdata(ds_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid = '0; req_rw = '0; req_rdindex = '0; req_wrindex = '0; req_data = '0;
    ds_ready = 1'b0; ds_rdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    if (req_ready !== 4'b0) begin fails++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end checks++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end checks++;
    if (rsp_id !== 2'd0) begin fails++; $display("FAIL rst_rsp_id got %0d want 0", rsp_id); end checks++;
    if (rsp_data !== 32'h0) begin fails++; $display("FAIL rst_rsp_data got %h want 0", rsp_data); end checks++;
    if (rsp_err !== 1'b0) begin fails++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end checks++;
    if (ds_valid !== 1'b0) begin fails++; $display("FAIL rst_ds_valid got %b want 0", ds_valid); end checks++;
    if (ds_rw !== 1'b0) begin fails++; $display("FAIL rst_ds_rw got %b want 0", ds_rw); end checks++;
    if ({ds_rdindex, ds_wrindex, ds_data} !== 96'h0) begin fails++; $display("FAIL rst_ds_fields got %h want 0", {ds_rdindex, ds_wrindex, ds_data}); end checks++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    req_valid = 4'b0100; req_rw = 4'b0100;
    req_wrindex[2*32 +: 32] = 32'h5; req_data[2*32 +: 32] = 32'h10;
    #1;
    if (req_ready !== 4'b0100) begin fails++; $display("FAIL wr_grant got %b want 0100", req_ready); end checks++;
    @(negedge clk); req_valid = '0; #1;
    if (req_ready !== 4'b0) begin fails++; $display("FAIL wr_grant_once got %b want 0000", req_ready); end checks++;
    if (ds_valid !== 1'b1) begin fails++; $display("FAIL wr_ds_valid got %b want 1", ds_valid); end checks++;
    if (ds_rw !== 1'b1) begin fails++; $display("FAIL wr_ds_rw got %b want 1", ds_rw); end checks++;
    if (ds_wrindex !== 32'h5) begin fails++; $display("FAIL wr_ds_wrindex got %h want 5", ds_wrindex); end checks++;
    if (ds_data !== 32'h10) begin fails++; $display("FAIL wr_ds_data got %h want 10", ds_data); end checks++;
    @(negedge clk); ds_ready = 1'b1; ds_rdata = 32'hBEEF; #1;
    if (ds_wrindex !== 32'h5 || ds_valid !== 1'b1) begin fails++; $display("FAIL wr_ds_hold got %h/%b want 5/1", ds_wrindex, ds_valid); end checks++;
    @(negedge clk); ds_ready = 1'b0; #1;
    if (rsp_valid !== 1'b1) begin fails++; $display("FAIL wr_rsp_valid got %b want 1", rsp_valid); end checks++;
    if (rsp_id !== 2'd2) begin fails++; $display("FAIL wr_rsp_id got %0d want 2", rsp_id); end checks++;
    if (rsp_data !== 32'h0) begin fails++; $display("FAIL wr_rsp_data got %h want 0", rsp_data); end checks++;
    if (rsp_err !== 1'b0) begin fails++; $display("FAIL wr_rsp_err got %b want 0", rsp_err); end checks++;
    if (ds_valid !== 1'b0) begin fails++; $display("FAIL wr_ds_drop got %b want 0", ds_valid); end checks++;
    @(negedge clk); #1;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd2) begin fails++; $display("FAIL wr_rsp_hold got %b/%0d want 0/2", rsp_valid, rsp_id); end checks++;
  endtask

  task automatic test_read();
    req_valid = 4'b0001; req_rw = 4'b0000; req_rdindex[0 +: 32] = 32'h3;
    #1;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL rd_grant got %b want 0001", req_ready); end checks++;
    @(negedge clk); req_valid = '0; ds_ready = 1'b1; ds_rdata = 32'hCAFE; #1;
    if (ds_rdindex !== 32'h3 || ds_rw !== 1'b0) begin fails++; $display("FAIL rd_ds_req got %h/%b want 3/0", ds_rdindex, ds_rw); end checks++;
    @(negedge clk); ds_ready = 1'b0; ds_rdata = 32'h0; #1;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin fails++; $display("FAIL rd_rsp got %b/%0d want 1/0", rsp_valid, rsp_id); end checks++;
    if (rsp_data !== 32'hCAFE) begin fails++; $display("FAIL rd_rsp_data got %h want cafe", rsp_data); end checks++;
    @(negedge clk); #1;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'hCAFE) begin fails++; $display("FAIL rd_rsp_hold got %b/%h want 0/cafe", rsp_valid, rsp_data); end checks++;
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    apply_reset();
    req_valid = 4'b1111; ds_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      #1;
      exp = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0;
      if (req_ready !== exp) begin fails++; $display("FAIL rr_grant c%0d got %b want %b", c, req_ready, exp); end checks++;
      if (c % 3 == 2) begin
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((c / 3) % 4)) begin fails++; $display("FAIL rr_rsp c%0d got %b/%0d want 1/%0d", c, rsp_valid, rsp_id, (c / 3) % 4); end checks++;
      end
      @(negedge clk);
    end
    req_valid = '0; ds_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int  n;
    logic seen;
    apply_reset();
    req_valid = 4'b0010; #1;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL to_grant got %b want 0010", req_ready); end checks++;
    @(negedge clk); req_valid = '0; ds_rdata = 32'h1234;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rsp_valid) begin seen = 1'b1; break; end
      if (ds_valid) n++;
      @(negedge clk);
    end
    if (seen !== 1'b1) begin fails++; $display("FAIL to_rsp_seen got %b want 1", seen); end checks++;
    if (n != 16) begin fails++; $display("FAIL to_wait_cycles got %0d want 16", n); end checks++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'h0) begin fails++; $display("FAIL to_err got %b/%h want 1/0", rsp_err, rsp_data); end checks++;
    @(negedge clk);
    req_valid = 4'b0010; #1;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL to2_grant got %b want 0010", req_ready); end checks++;
    @(negedge clk); req_valid = '0;
    repeat (15) @(negedge clk);
    ds_ready = 1'b1; ds_rdata = 32'h77; #1;
    if (ds_valid !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL to2_still_wait got %b/%b want 1/0", ds_valid, rsp_valid); end checks++;
    @(negedge clk); ds_ready = 1'b0; #1;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h77) begin fails++; $display("FAIL to2_late_ready got %b/%b/%h want 1/0/77", rsp_valid, rsp_err, rsp_data); end checks++;
  endtask

  task automatic test_reset_midwait();
    @(negedge clk);
    req_valid = 4'b0100; #1;
    if (req_ready !== 4'b0100) begin fails++; $display("FAIL rm_grant got %b want 0100", req_ready); end checks++;
    @(negedge clk); req_valid = '0; #1;
    if (ds_valid !== 1'b1) begin fails++; $display("FAIL rm_wait got %b want 1", ds_valid); end checks++;
    #2 rst_n = 1'b0; #1;
    if (ds_valid !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rm_async got %b/%b want 0/0", ds_valid, rsp_valid); end checks++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin fails++; $display("FAIL rm_quiet got %b/%b want 0/0000", rsp_valid, req_ready); end checks++;
    end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b1010; #1;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL rm_restart got %b want 0010", req_ready); end checks++;
    @(negedge clk); req_valid = '0; ds_ready = 1'b1; #1;
    @(negedge clk); ds_ready = 1'b0; #1;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin fails++; $display("FAIL rm_rsp got %b/%0d want 1/1", rsp_valid, rsp_id); end checks++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fairness();
    test_timeout();
    test_reset_midwait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
